// File: rtl/fb_writer.sv
// Frame-buffer writer: raster RGB stream -> RAM port A, rows offset by a circular base.
// Define FB_WRITER_CLEAR_EN to add a full-frame clear to clr_color_i.
//
// state   | meaning
// S_IDLE  | waiting for a start-of-frame beat; non-sof beats are dropped
// S_FILL  | writing pixels in raster order
// S_DONE  | one-cycle frame_done pulse, not ready
// S_CLEAR | (optional) writing clr_color_i to every address
module fb_writer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sof_i,
  output logic              in_ready_o,
  input  logic [7:0]        row_base_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              sync_err_o
`ifdef FB_WRITER_CLEAR_EN
  ,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] clr_color_i
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DONE  = 2'd2
`ifdef FB_WRITER_CLEAR_EN
    ,
    S_CLEAR = 2'd3
`endif
  } state_t;

  localparam logic [8:0]        X_LAST  = 9'(H_RES - 1);
  localparam logic [7:0]        Y_LAST  = 8'(V_RES - 1);
  localparam logic [8:0]        V_RES_W = 9'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  state_t              state_q, state_d;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [7:0]          base_q, base_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                sync_err_q, sync_err_d;

  logic                accept, sof_beat, idle_ready;
  logic [7:0]          base_new, wr_y, wr_base;
  logic [8:0]          wr_x, row_sum, row;
  logic [ADDR_W-1:0]   wr_addr;

`ifdef FB_WRITER_CLEAR_EN
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  assign idle_ready = !clr_i;
`else
  assign idle_ready = 1'b1;
`endif

  assign in_ready_o = !rst_i && ((state_q == S_IDLE && idle_ready) || state_q == S_FILL);
  assign accept     = in_valid_i && in_ready_o;
  assign sof_beat   = accept && in_sof_i;

  // An out-of-range base would break the single conditional subtract, so it falls back to 0.
  assign base_new = ({1'b0, row_base_i} >= V_RES_W) ? 8'd0 : row_base_i;

  // A sof beat always lands at (0,0) against the freshly latched base.
  assign wr_x    = sof_beat ? 9'd0 : x_q;
  assign wr_y    = sof_beat ? 8'd0 : y_q;
  assign wr_base = sof_beat ? base_new : base_q;
  assign row_sum = {1'b0, wr_y} + {1'b0, wr_base};
  assign row     = (row_sum >= V_RES_W) ? row_sum - V_RES_W : row_sum;
  assign wr_addr = ADDR_W'(row) * H_RES_A + ADDR_W'(wr_x);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    base_d     = base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    sync_err_d = 1'b0;
`ifdef FB_WRITER_CLEAR_EN
    clr_addr_d = clr_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef FB_WRITER_CLEAR_EN
        if (clr_i) begin
          clr_addr_d = '0;
          state_d    = S_CLEAR;
        end else
`endif
        if (sof_beat) begin
          base_d  = base_new;
          we_d    = 1'b1;
          addr_d  = wr_addr;
          din_d   = in_data_i;
          x_d     = 9'd1;
          y_d     = 8'd0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = wr_addr;
          din_d  = in_data_i;
          if (sof_beat) begin
            base_d     = base_new;
            x_d        = 9'd1;
            y_d        = 8'd0;
            sync_err_d = 1'b1;
          end else if (x_q == X_LAST) begin
            x_d = 9'd0;
            if (y_q == Y_LAST) begin
              y_d     = 8'd0;
              state_d = S_DONE;
            end else begin
              y_d = y_q + 8'd1;
            end
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef FB_WRITER_CLEAR_EN
      S_CLEAR: begin
        we_d   = 1'b1;
        addr_d = clr_addr_q;
        din_d  = clr_color_i;
        if (clr_addr_q == ADDR_LAST) state_d = S_DONE;
        else clr_addr_d = clr_addr_q + ADDR_W'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      sync_err_q <= 1'b0;
`ifdef FB_WRITER_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      base_q     <= base_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      sync_err_q <= sync_err_d;
`ifdef FB_WRITER_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_din_o    = din_q;
  assign sync_err_o   = sync_err_q;
  assign frame_done_o = (state_q == S_DONE);
`ifdef FB_WRITER_CLEAR_EN
  assign busy_o = (state_q == S_FILL) || (state_q == S_CLEAR);
`else
  assign busy_o = (state_q == S_FILL);
`endif

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Frame-buffer writer: accepts a raster-ordered 12-bit RGB pixel stream over a valid/ready handshake.
- Writes each pixel into the 320x240 single-port block RAM port A (wea/addra/dina) that the VGA display path reads.
- Supports a row-base offset latched at start of frame, so captured images land at the same circular row offset the scrolling display uses.
- Sits between a pixel source (pattern generator, UART loader, camera front end) and the frame-buffer RAM.

Parameters:
- H_RES, 320, pixels per row
- V_RES, 240, rows per frame
- ADDR_W, 17, memory address width (H_RES*V_RES = 76800 fits)
- DATA_W, 12, pixel width, {R[3:0],G[3:0],B[3:0]}

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  source has a pixel beat
- in_data  in  DATA_W  pixel value
- in_sof  in  1  start-of-frame marker, qualified by in_valid
- in_ready  out  1  writer accepts beat this cycle
- row_base  in  8  starting row offset, sampled on the sof beat
- mem_we  out  1  RAM write enable (drives wea)
- mem_addr  out  ADDR_W  RAM address (drives addra)
- mem_din  out  DATA_W  RAM write data (drives dina)
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse after last pixel of a frame is written
- sync_err  out  1  one-cycle pulse when sof arrives mid-frame

Behaviour:
- Beat accepted when in_valid && in_ready.
- Reset (rst=1 at posedge):
  - state=IDLE, x=0, y=0, base=0.
  - mem_we=0, mem_addr=0, mem_din=0, busy=0, frame_done=0, sync_err=0.
  - in_ready=0 during the reset cycle, 1 in the first cycle after.
  - Reset mid-frame abandons the frame; no further writes occur.
- States: IDLE, FILL, DONE (plus CLEAR with the optional feature).
- IDLE:
  - in_ready=1.
  - Beats without in_sof are consumed and discarded; no write.
  - Beat with in_sof: latch base=row_base (row_base>=V_RES latches 0), write pixel (0,0), set x=1, go to FILL.
- FILL:
  - in_ready=1, busy=1.
  - Each accepted beat writes pixel (x,y), then x increments.
  - x wraps H_RES-1 -> 0 with y+1.
  - Beat at (H_RES-1, V_RES-1) writes, then goes to DONE.
- DONE:
  - Lasts exactly one cycle.
  - in_ready=0, frame_done=1, busy=0.
  - Then IDLE.
- sof in FILL:
  - Resynchronise: the beat is written as pixel (0,0), base is relatched, x=1, y=0.
  - sync_err pulses 1 cycle; frame_done is not asserted for the aborted frame.
- Address:
  - row = y+base; if row>=V_RES then row-V_RES.
  - mem_addr = row*H_RES + x. No modulo operator; single conditional subtract.
- Latency:
  - mem_we/mem_addr/mem_din are registered, valid exactly 1 cycle after the accepting edge.
  - mem_we=0 on all cycles with no accepted write.
- Gaps:
  - in_valid=0 mid-frame holds x/y indefinitely.
  - No timeout.
- Width: x is 9 bits, y and row are 8 bits, the address product is ADDR_W bits; no truncation is permitted.

Optional Feature:
- Macro: FB_WRITER_CLEAR_EN
- Defined:
  - Adds ports clr (in, 1) and clr_color (in, DATA_W).
  - clr=1 in IDLE enters CLEAR: busy=1, in_ready=0.
  - Writes clr_color to addresses 0..H_RES*V_RES-1, one per cycle, ignoring base.
  - Then DONE (frame_done pulses), then IDLE.
  - clr in FILL/DONE is ignored. Reset during CLEAR stops it immediately.
- Undefined: no clr ports; CLEAR state is absent; behaviour is otherwise identical.

Test Plan:
- Reset, then stream 76800 beats with sof on the first, row_base=0, data=address[11:0] -> mem_addr 0..76799 in order, one cycle after each accept; frame_done pulses once, 1 cycle after the last write; in_ready=0 that cycle.
- row_base=10, full frame -> pixel (0,0) at addr 3200; pixel (0,230) at addr 0; pixel (319,229) at addr 76799.
- 5 beats before sof, then sof frame -> first 5 beats produce mem_we=0; first write is addr 0.
- sof re-asserted at pixel (5,3) with row_base=2 -> sync_err 1-cycle pulse; that beat written at addr 640; no frame_done until a complete 76800-beat frame finishes.
- in_valid toggled randomly (50%) across a frame -> writes identical to the gapless case; busy stays high throughout.
- With FB_WRITER_CLEAR_EN: clr with clr_color=12'hF00 -> 76800 consecutive writes of 12'hF00 to addr 0..76799, in_ready=0 throughout, then frame_done. Repeat with rst asserted at write 1000 -> no writes after the reset edge.
